// File: rtl/scalar_rf_requester.sv
// scalar_rf_requester: in-order command FIFO driving register-file write/read val/rdy transactions; `RF_TIMEOUT_EN adds a watchdog
module scalar_rf_requester #(
  parameter int NUM_PORTS = 1,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cmd_val,
  output logic          o_cmd_rdy,
  input  logic          i_cmd_wr,
  input  logic [4:0]    i_cmd_idx,
  input  logic [PW-1:0] i_cmd_port,
  input  logic [31:0]   i_cmd_data,
  output logic          o_resp_val,
  input  logic          i_resp_rdy,
  output logic [31:0]   o_resp_data,
  output logic [4:0]    o_resp_idx,
  output logic          o_resp_err,
  output logic          o_busy,
  output logic [31:0]   o_rf_recv_msg,
  output logic [4:0]    o_rf_recv_idx,
  output logic          o_rf_recv_val,
  input  logic          i_rf_recv_rdy,
  output logic [4:0]    o_rf_send_idx [NUM_PORTS],
  input  logic [31:0]   i_rf_send_msg [NUM_PORTS],
  input  logic          i_rf_send_val [NUM_PORTS],
  output logic          o_rf_send_rdy [NUM_PORTS]
);
  localparam int AW = $clog2(CMD_DEPTH);
  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;
  typedef struct packed {
    logic          wr;
    logic [4:0]    idx;
    logic [PW-1:0] port;
    logic [31:0]   data;
  } cmd_t;
  cmd_t          r_mem [CMD_DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  state_t        r_state, w_next;
  logic          w_push, w_pop, w_to, w_sel_val, w_enter_resp;
  logic [31:0]   w_sel_msg, r_resp_data;
  logic [4:0]    r_resp_idx;
  logic [PW-1:0] w_port;
  cmd_t          w_head;
  assign w_head = r_mem[r_head];
  assign o_cmd_rdy = r_count != (AW+1)'(CMD_DEPTH);
  assign w_push = i_cmd_val && o_cmd_rdy;
  // out-of-range port selects fall back to port 0
  assign w_port = ({1'b0, w_head.port} < (PW+1)'(NUM_PORTS)) ? w_head.port : '0;
  always_comb begin
    w_sel_val = 1'b0;
    w_sel_msg = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (w_port == PW'(i)) begin
        w_sel_val = i_rf_send_val[i];
        w_sel_msg = i_rf_send_msg[i];
      end
  end
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign o_rf_send_rdy[p] = r_state == RD && w_port == PW'(p);
    assign o_rf_send_idx[p] = o_rf_send_rdy[p] ? w_head.idx : '0;
  end
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    case (r_state)
      IDLE: if (|r_count) w_next = w_head.wr ? WR : RD;
      WR: if (i_rf_recv_rdy) begin
        w_next = IDLE;
        w_pop = 1'b1;
      end else if (w_to) w_next = RESP;
      RD: if (w_sel_val || w_to) w_next = RESP;
      RESP: if (i_resp_rdy) begin
        w_next = IDLE;
        w_pop = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_enter_resp = w_next == RESP && r_state != RESP;
  assign o_rf_recv_val = r_state == WR;
  assign o_rf_recv_msg = o_rf_recv_val ? w_head.data : '0;
  assign o_rf_recv_idx = o_rf_recv_val ? w_head.idx : '0;
  assign o_resp_val = r_state == RESP;
  assign o_resp_data = r_resp_data;
  assign o_resp_idx = r_resp_idx;
  assign o_busy = |r_count || r_state != IDLE;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= IDLE;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_resp_data <= '0;
      r_resp_idx <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop) r_head <= r_head + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_enter_resp) begin
        r_resp_data <= (r_state == RD && w_sel_val) ? w_sel_msg : '0;
        r_resp_idx <= w_head.idx;
      end
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_tail] <= {i_cmd_wr, i_cmd_idx, i_cmd_port, i_cmd_data};
`ifdef RF_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;
  assign w_to = (r_state == WR || r_state == RD) && r_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign o_resp_err = r_err && o_resp_val;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == WR || r_state == RD) ? r_cnt + 8'd1 : '0;
      if (w_enter_resp) r_err <= !(r_state == RD && w_sel_val);
    end
`else
  assign w_to = 1'b0;
  assign o_resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_scalar_rf_requester.sv
// tb_scalar_rf_requester: directed checks of the requester with two read ports
module tb_scalar_rf_requester;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_val = 1'b0, cmd_rdy, cmd_wr = 1'b0;
  logic [4:0]  cmd_idx = '0;
  logic [0:0]  cmd_port = '0;
  logic [31:0] cmd_data = '0;
  logic        resp_val, resp_rdy = 1'b0, resp_err, busy;
  logic [31:0] resp_data, rf_recv_msg;
  logic [4:0]  resp_idx, rf_recv_idx;
  logic        rf_recv_val, rf_recv_rdy = 1'b0;
  logic [4:0]  rf_send_idx [2];
  logic [31:0] rf_send_msg [2];
  logic        rf_send_val [2];
  logic        rf_send_rdy [2];
  int          errors = 0, checks = 0;
  logic [4:0]  wr_log [$];

  scalar_rf_requester #(.NUM_PORTS(2)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cmd_val(cmd_val), .o_cmd_rdy(cmd_rdy), .i_cmd_wr(cmd_wr),
    .i_cmd_idx(cmd_idx), .i_cmd_port(cmd_port), .i_cmd_data(cmd_data),
    .o_resp_val(resp_val), .i_resp_rdy(resp_rdy), .o_resp_data(resp_data),
    .o_resp_idx(resp_idx), .o_resp_err(resp_err), .o_busy(busy),
    .o_rf_recv_msg(rf_recv_msg), .o_rf_recv_idx(rf_recv_idx),
    .o_rf_recv_val(rf_recv_val), .i_rf_recv_rdy(rf_recv_rdy),
    .o_rf_send_idx(rf_send_idx), .i_rf_send_msg(rf_send_msg),
    .i_rf_send_val(rf_send_val), .o_rf_send_rdy(rf_send_rdy)
  );

  always #5 clk = ~clk;

  // a write transfer holds val&&rdy for exactly one full cycle, so log it mid-cycle
  always @(negedge clk) if (rf_recv_val && rf_recv_rdy) wr_log.push_back(rf_recv_idx);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [4:0] idx, input logic [0:0] port, input logic [31:0] data);
    cmd_val = 1'b1; cmd_wr = wr; cmd_idx = idx; cmd_port = port; cmd_data = data;
    tick();
    cmd_val = 1'b0;
  endtask

  task automatic test_reset();
    rf_send_val[0] = 1'b0; rf_send_val[1] = 1'b0;
    rf_send_msg[0] = '0; rf_send_msg[1] = '0;
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy: got %b expected 1", cmd_rdy); end
    checks++; if (resp_val !== 1'b0) begin errors++; $display("FAIL reset_resp_val: got %b expected 0", resp_val); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rf_recv_val !== 1'b0) begin errors++; $display("FAIL reset_recv_val: got %b expected 0", rf_recv_val); end
    checks++; if (rf_send_rdy[0] !== 1'b0 || rf_send_rdy[1] !== 1'b0) begin errors++; $display("FAIL reset_send_rdy: got %b%b expected 00", rf_send_rdy[1], rf_send_rdy[0]); end
    checks++; if (rf_recv_msg !== 32'h0 || rf_recv_idx !== 5'd0) begin errors++; $display("FAIL reset_recv_data: got %h/%0d expected 0/0", rf_recv_msg, rf_recv_idx); end
    checks++; if (resp_data !== 32'h0 || resp_idx !== 5'd0) begin errors++; $display("FAIL reset_resp_data: got %h/%0d expected 0/0", resp_data, resp_idx); end
    checks++; if (rf_send_idx[0] !== 5'd0 || rf_send_idx[1] !== 5'd0) begin errors++; $display("FAIL reset_send_idx: got %0d/%0d expected 0/0", rf_send_idx[0], rf_send_idx[1]); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wr_log.delete();
    rf_recv_rdy = 1'b1;
    push(1'b1, 5'd5, 1'b0, 32'hDEADBEEF);
    checks++; if (rf_recv_val !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_accept: got val=%b busy=%b expected val=0 busy=1", rf_recv_val, busy); end
    tick();
    checks++; if (rf_recv_val !== 1'b1 || rf_recv_idx !== 5'd5 || rf_recv_msg !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_drive: got val=%b idx=%0d msg=%h expected 1/5/deadbeef", rf_recv_val, rf_recv_idx, rf_recv_msg); end
    tick();
    checks++; if (rf_recv_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_done: got val=%b busy=%b expected 0/0", rf_recv_val, busy); end
    rf_recv_rdy = 1'b0;
    rf_send_val[0] = 1'b1; rf_send_msg[0] = 32'hDEADBEEF;
    push(1'b0, 5'd5, 1'b0, 32'h0);
    tick();
    checks++; if (rf_send_rdy[0] !== 1'b1 || rf_send_idx[0] !== 5'd5 || rf_send_rdy[1] !== 1'b0) begin errors++; $display("FAIL rd_drive: got rdy0=%b idx0=%0d rdy1=%b expected 1/5/0", rf_send_rdy[0], rf_send_idx[0], rf_send_rdy[1]); end
    checks++; if (resp_val !== 1'b0) begin errors++; $display("FAIL rd_early_resp: got %b expected 0", resp_val); end
    tick();
    checks++; if (resp_val !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_idx !== 5'd5 || resp_err !== 1'b0) begin errors++; $display("FAIL rd_resp: got val=%b data=%h idx=%0d err=%b expected 1/deadbeef/5/0", resp_val, resp_data, resp_idx, resp_err); end
    checks++; if (rf_send_rdy[0] !== 1'b0) begin errors++; $display("FAIL rd_rdy_drop: got %b expected 0", rf_send_rdy[0]); end
    rf_send_val[0] = 1'b0;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    checks++; if (resp_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_done: got val=%b busy=%b expected 0/0", resp_val, busy); end
    checks++; if (wr_log.size() !== 1) begin errors++; $display("FAIL wr_xfer_count: got %0d expected 1", wr_log.size()); end
  endtask

  task automatic test_backpressure();
    rf_recv_rdy = 1'b0;
    push(1'b1, 5'd9, 1'b0, 32'h12345678);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (rf_recv_val !== 1'b1 || rf_recv_idx !== 5'd9 || rf_recv_msg !== 32'h12345678) begin errors++; $display("FAIL wr_hold_%0d: got val=%b idx=%0d msg=%h expected 1/9/12345678", i, rf_recv_val, rf_recv_idx, rf_recv_msg); end
    end
    rf_recv_rdy = 1'b1;
    tick();
    rf_recv_rdy = 1'b0;
    checks++; if (rf_recv_val !== 1'b0) begin errors++; $display("FAIL wr_release: got %b expected 0", rf_recv_val); end
    rf_send_val[0] = 1'b1; rf_send_msg[0] = 32'hCAFEF00D;
    push(1'b0, 5'd9, 1'b0, 32'h0);
    tick();
    tick();
    rf_send_val[0] = 1'b0; rf_send_msg[0] = 32'h0BADBAD0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_val !== 1'b1 || resp_data !== 32'hCAFEF00D || resp_idx !== 5'd9) begin errors++; $display("FAIL resp_hold_%0d: got val=%b data=%h idx=%0d expected 1/cafef00d/9", i, resp_val, resp_data, resp_idx); end
      tick();
    end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    checks++; if (resp_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL resp_release: got val=%b busy=%b expected 0/0", resp_val, busy); end
  endtask

  task automatic test_fifo_full();
    rf_recv_rdy = 1'b0;
    wr_log.delete();
    for (int i = 1; i <= 4; i++) begin
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_before_%0d: got %b expected 1", i, cmd_rdy); end
      push(1'b1, 5'(i), 1'b0, 32'h100 + i);
    end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_low: got %b expected 0", cmd_rdy); end
    tick();
    checks++; if (cmd_rdy !== 1'b0 || rf_recv_idx !== 5'd1) begin errors++; $display("FAIL full_hold: got rdy=%b idx=%0d expected 0/1", cmd_rdy, rf_recv_idx); end
    rf_recv_rdy = 1'b1;
    tick();
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL full_first_pop: got %b expected 1", cmd_rdy); end
    for (int i = 0; i < 20 && busy; i++) tick();
    rf_recv_rdy = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain: busy=%b expected 0 within 20 cycles", busy); end
    checks++; if (wr_log.size() !== 4) begin errors++; $display("FAIL full_count: got %0d expected 4", wr_log.size()); end
    for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== 5'(i + 1)) begin errors++; $display("FAIL full_order_%0d: got %0d expected %0d", i, wr_log[i], i + 1); end
    end
  endtask

  task automatic test_back_to_back();
    rf_recv_rdy = 1'b1;
    wr_log.delete();
    cmd_val = 1'b1; cmd_wr = 1'b1; cmd_idx = 5'd10; cmd_data = 32'hA;
    tick();
    cmd_idx = 5'd11; cmd_data = 32'hB;
    tick();
    cmd_val = 1'b0;
    checks++; if (rf_recv_val !== 1'b1 || rf_recv_idx !== 5'd10) begin errors++; $display("FAIL b2b_first: got val=%b idx=%0d expected 1/10", rf_recv_val, rf_recv_idx); end
    tick();
    checks++; if (rf_recv_val !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap: got val=%b busy=%b expected 0/1", rf_recv_val, busy); end
    tick();
    checks++; if (rf_recv_val !== 1'b1 || rf_recv_idx !== 5'd11 || rf_recv_msg !== 32'hB) begin errors++; $display("FAIL b2b_second: got val=%b idx=%0d msg=%h expected 1/11/b", rf_recv_val, rf_recv_idx, rf_recv_msg); end
    tick();
    rf_recv_rdy = 1'b0;
    checks++; if (busy !== 1'b0 || wr_log.size() !== 2) begin errors++; $display("FAIL b2b_done: got busy=%b xfers=%0d expected 0/2", busy, wr_log.size()); end
  endtask

  task automatic test_multiport();
    push(1'b0, 5'd3, 1'b1, 32'h0);
    tick();
    checks++; if (rf_send_rdy[1] !== 1'b1 || rf_send_idx[1] !== 5'd3) begin errors++; $display("FAIL mp_sel: got rdy1=%b idx1=%0d expected 1/3", rf_send_rdy[1], rf_send_idx[1]); end
    checks++; if (rf_send_rdy[0] !== 1'b0 || rf_send_idx[0] !== 5'd0) begin errors++; $display("FAIL mp_unsel: got rdy0=%b idx0=%0d expected 0/0", rf_send_rdy[0], rf_send_idx[0]); end
    rf_send_val[0] = 1'b1; rf_send_msg[0] = 32'hBAD0BAD0;
    tick();
    checks++; if (resp_val !== 1'b0 || rf_send_rdy[1] !== 1'b1) begin errors++; $display("FAIL mp_wrong_port: got resp_val=%b rdy1=%b expected 0/1", resp_val, rf_send_rdy[1]); end
    rf_send_val[1] = 1'b1; rf_send_msg[1] = 32'h00000033;
    tick();
    rf_send_val[0] = 1'b0; rf_send_val[1] = 1'b0;
    checks++; if (resp_val !== 1'b1 || resp_data !== 32'h33 || resp_idx !== 5'd3) begin errors++; $display("FAIL mp_resp: got val=%b data=%h idx=%0d expected 1/00000033/3", resp_val, resp_data, resp_idx); end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    push(1'b0, 5'd7, 1'b0, 32'h0);
    tick();
    checks++; if (rf_send_rdy[0] !== 1'b1) begin errors++; $display("FAIL mid_rd_enter: got %b expected 1", rf_send_rdy[0]); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rf_send_rdy[0] !== 1'b0 || busy !== 1'b0 || cmd_rdy !== 1'b1 || resp_val !== 1'b0) begin errors++; $display("FAIL mid_rd_reset: got rdy0=%b busy=%b cmd_rdy=%b resp_val=%b expected 0/0/1/0", rf_send_rdy[0], busy, cmd_rdy, resp_val); end
    tick();
    reset = 1'b0;
    rf_send_val[0] = 1'b1; rf_send_msg[0] = 32'h77;
    resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (resp_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rd_after_%0d: got resp_val=%b busy=%b expected 0/0", i, resp_val, busy); end
    end
    rf_send_val[0] = 1'b0;
    resp_rdy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_fifo_full();
    test_back_to_back();
    test_multiport();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
